// File: rtl/uart_debug_ctrl_if.sv
// uart_debug_ctrl_if: byte-level rx/tx handshake between the UART and uart_debug_ctrl.
interface uart_debug_ctrl_if;
    logic       rx_done_tick;
    logic [7:0] rx_bus;
    logic       tx_done_tick;
    logic       tx_start;
    logic [7:0] tx_bus;
    modport master (input rx_done_tick, rx_bus, tx_done_tick, output tx_start, tx_bus);
    modport slave (output rx_done_tick, rx_bus, tx_done_tick, input tx_start, tx_bus);
endinterface

// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: host-command sequencer that resets/steps/runs the debug pipeline and dumps a bus snapshot.
// Optional UART_DBG_CHECKSUM_EN appends an XOR byte of the snapshot to every dump.
module uart_debug_ctrl #(
    parameter int BUS_W        = 144,
    parameter int INSTR_W      = 32,
    parameter int STEP_CYCLES  = 2,
    parameter int RESET_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_debug_ctrl_if.master        uart,
    output logic                     clockPipeline,
    input  logic [BUS_W-1:0]         bus_UART,
    input  logic [INSTR_W-1:0]       instruccion,
    output logic                     resetUART,
    output logic                     busy
);
    localparam int SNAP_W = BUS_W + INSTR_W;
    localparam int NB     = SNAP_W / 8;
`ifdef UART_DBG_CHECKSUM_EN
    localparam int NT     = NB + 1;
`else
    localparam int NT     = NB;
`endif
    localparam int CMAX   = (STEP_CYCLES > RESET_CYCLES) ? STEP_CYCLES : RESET_CYCLES;
    localparam int CNT_W  = $clog2(CMAX + 1);
    localparam int LEFT_W = $clog2(NT + 1);
    localparam logic [CNT_W-1:0] STEP_END = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_END  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [SNAP_W-9:0] PAD     = '0;

    typedef enum logic [2:0] {IDLE, RSTP, STEP_HI, STEP_LO, SNAP, LOAD, WAIT_TX, RUN} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [LEFT_W-1:0]   left, left_n;
    logic [SNAP_W-1:0]   shreg, shreg_n, snap;
    logic                boot, boot_n, halt, halt_n, ckp_n;
    logic [7:0]          fill;

    assign snap = {bus_UART, instruccion};
    assign busy = !(state == IDLE || state == RUN);

`ifdef UART_DBG_CHECKSUM_EN
    logic [7:0] csum, csum_calc;
    always_comb begin
        csum_calc = '0;
        for (int i = 0; i < NB; i++) csum_calc = csum_calc ^ snap[i*8 +: 8];
    end
    // every shift pulls the checksum in at the bottom, so it surfaces once the snapshot bytes are gone
    assign fill = csum;
    always_ff @(posedge clk) csum <= reset ? '0 : (state == SNAP ? csum_calc : csum);
`else
    assign fill = 8'h00;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        left_n  = left;
        shreg_n = shreg;
        boot_n  = boot;
        halt_n  = halt;
        ckp_n   = clockPipeline;
        unique case (state)
            IDLE: begin
                cnt_n  = '0;
                halt_n = 1'b0;
                if (uart.rx_done_tick) begin
                    case (uart.rx_bus)
                        8'h72: state_n = RSTP;
                        8'h73: begin state_n = STEP_HI; ckp_n = 1'b1; end
                        8'h64: state_n = SNAP;
                        8'h63: begin state_n = RUN; ckp_n = 1'b1; end
                        8'h68: state_n = IDLE;
                        default: begin
                            state_n = LOAD;
                            shreg_n = {8'h3F, PAD};
                            left_n  = LEFT_W'(1);
                        end
                    endcase
                end
            end
            RSTP: if (cnt == RST_END) begin
                cnt_n   = '0;
                boot_n  = 1'b0;
                state_n = boot ? IDLE : LOAD;
                shreg_n = {8'h6B, PAD};
                left_n  = LEFT_W'(1);
            end
            STEP_HI: if (cnt == STEP_END) begin
                state_n = STEP_LO;
                ckp_n   = 1'b0;
                cnt_n   = '0;
            end
            STEP_LO: if (cnt == STEP_END) begin
                state_n = SNAP;
                cnt_n   = '0;
            end
            SNAP: begin
                state_n = LOAD;
                shreg_n = snap;
                left_n  = LEFT_W'(NT);
            end
            LOAD: state_n = WAIT_TX;
            WAIT_TX: if (uart.tx_done_tick) begin
                shreg_n = {shreg[SNAP_W-9:0], fill};
                left_n  = left - 1'b1;
                state_n = (left == LEFT_W'(1)) ? IDLE : LOAD;
            end
            RUN: begin
                halt_n = halt | (uart.rx_done_tick && uart.rx_bus == 8'h68);
                // only leave at the end of a complete low phase so the pipeline never sees a short pulse
                if (cnt == STEP_END) begin
                    cnt_n = '0;
                    if (!clockPipeline && halt_n) begin
                        state_n = SNAP;
                        halt_n  = 1'b0;
                    end else ckp_n = ~clockPipeline;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RSTP;
            cnt           <= '0;
            left          <= '0;
            shreg         <= '0;
            boot          <= 1'b1;
            halt          <= 1'b0;
            clockPipeline <= 1'b0;
            resetUART     <= 1'b1;
            uart.tx_start <= 1'b0;
            uart.tx_bus   <= 8'h00;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            left          <= left_n;
            shreg         <= shreg_n;
            boot          <= boot_n;
            halt          <= halt_n;
            clockPipeline <= ckp_n;
            resetUART     <= state_n == RSTP;
            uart.tx_start <= state_n == LOAD;
            if (state_n == LOAD) uart.tx_bus <= shreg_n[SNAP_W-1 -: 8];
        end
    end
endmodule
